// File: rtl/store_monitor_pkg.sv
// Shared types for the store monitor: run-state encoding and the store-log entry.
package store_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// Store log FIFO. Keeps the last popped head visible while empty so the
// log_addr/log_data outputs hold their values on an idle or empty pop.
// A push into a full FIFO is dropped and sets the sticky overflow flag,
// unless a pop is accepted in the same cycle.
module store_log_fifo
    import store_monitor_pkg::*;
#(
    parameter int LOG_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  log_entry_t din,
    output log_entry_t dout,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(LOG_DEPTH);

    log_entry_t     mem [LOG_DEPTH];
    log_entry_t     last;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(LOG_DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? last : mem[rd_ptr];

    // Storage array; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset && !clr && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer, occupancy, held-head and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_monitor.sv
// Store monitor: watches processor stores and declares pass, fail or timeout.
// Optional macro STORE_MONITOR_STRICT_EN: any store other than the pass
// store or a scratch-address store ends the run with a fail verdict.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_RUN     | monitoring; counting cycles, counting and logging stores
// ST_PASS    | pass store seen; terminal until clear/reset
// ST_FAIL    | illegal store seen (strict build); terminal
// ST_TIMEOUT | cycle budget exhausted; terminal, reported as fail too
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        clear,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    input  logic        log_pop,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    state_t      state;
    state_t      state_next;
    logic [31:0] cyc_cnt;
    logic        store_ok;
    logic        pass_hit;
    logic        bad_store;
    logic        timeout_hit;
    logic        log_empty;
    logic        log_full;
    log_entry_t  log_in;
    log_entry_t  log_head;

    // A store only counts while running and not being cleared.
    assign store_ok    = memwrite && (state == ST_RUN) && !clear;
    assign pass_hit    = store_ok && (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
    assign timeout_hit = (state == ST_RUN) && (cyc_cnt == 32'(TIMEOUT_CYCLES - 1));

`ifdef STORE_MONITOR_STRICT_EN
    assign bad_store = store_ok &&
                       (((dataadr == PASS_ADDR) && (writedata != PASS_DATA)) ||
                        ((dataadr != PASS_ADDR) && (dataadr != SCRATCH_ADDR)));
`else
    assign bad_store = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a store verdict wins over a same-cycle timeout.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_RUN;
        end else if (state == ST_RUN) begin
            if (pass_hit) begin
                state_next = ST_PASS;
            end else if (bad_store) begin
                state_next = ST_FAIL;
            end else if (timeout_hit) begin
                state_next = ST_TIMEOUT;
            end
        end
    end

    // Registered verdict flags, aligned with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pass    <= 1'b0;
            fail    <= 1'b0;
            timeout <= 1'b0;
            done    <= 1'b0;
        end else begin
            pass    <= (state_next == ST_PASS);
            fail    <= (state_next == ST_FAIL) || (state_next == ST_TIMEOUT);
            timeout <= (state_next == ST_TIMEOUT);
            done    <= (state_next != ST_RUN);
        end
    end

    // Run-cycle counter and saturating store counter.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cyc_cnt     <= '0;
            store_count <= '0;
        end else begin
            if (state == ST_RUN) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (store_ok && (store_count != 16'hFFFF)) begin
                store_count <= store_count + 16'd1;
            end
        end
    end

    assign log_in = '{addr: dataadr, data: writedata};

    store_log_fifo #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .push     (store_ok),
        .pop      (log_pop),
        .din      (log_in),
        .dout     (log_head),
        .full     (log_full),
        .empty    (log_empty),
        .overflow (log_overflow)
    );

    assign log_valid = !log_empty;
    assign log_addr  = log_head.addr;
    assign log_data  = log_head.data;

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor (TIMEOUT_CYCLES=20, LOG_DEPTH=8).
// Honours STORE_MONITOR_STRICT_EN for the fail/timeout scenario.
module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        clear = 1'b0;
    logic        log_pop = 1'b0;
    logic        done, pass, fail, timeout;
    logic [15:0] store_count;
    logic        log_valid;
    logic [31:0] log_addr, log_data;
    logic        log_overflow;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          cnt;
        logic        pass;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[3];

    store_monitor #(
        .TIMEOUT_CYCLES (20),
        .LOG_DEPTH      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .clear        (clear),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .store_count  (store_count),
        .log_pop      (log_pop),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input bit logged);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        if (logged) sb.push_back('{a: a, d: d});
        step();
        memwrite = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".done"},     32'(done),         32'd0);
        chk({tag, ".pass"},     32'(pass),         32'd0);
        chk({tag, ".fail"},     32'(fail),         32'd0);
        chk({tag, ".timeout"},  32'(timeout),      32'd0);
        chk({tag, ".count"},    32'(store_count),  32'd0);
        chk({tag, ".valid"},    32'(log_valid),    32'd0);
        chk({tag, ".overflow"}, 32'(log_overflow), 32'd0);
        chk({tag, ".addr"},     log_addr,          32'd0);
        chk({tag, ".data"},     log_data,          32'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (sb.size() == 0) break;
            chk({tag, ".valid"}, 32'(log_valid), 32'd1);
            chk({tag, ".addr"},  log_addr, sb[0].a);
            chk({tag, ".data"},  log_data, sb[0].d);
            log_pop = 1'b1;
            step();
            log_pop = 1'b0;
            void'(sb.pop_front());
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s.drain: %0d entries left, required 0", tag, sb.size());
            sb.delete();
        end
        chk({tag, ".empty"}, 32'(log_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{a: 32'd80, d: 32'd5, cnt: 1, pass: 1'b0};
        vecs[1] = '{a: 32'd80, d: 32'd6, cnt: 2, pass: 1'b0};
        vecs[2] = '{a: 32'd84, d: 32'd7, cnt: 3, pass: 1'b1};

        // reset held low two cycles
        reset = 1'b0;
        step();
        step();
        chk_zero("reset");
        reset = 1'b1;

        // basic pass run from the table
        for (int i = 0; i < 3; i++) begin
            drive_store(vecs[i].a, vecs[i].d, 1'b1);
            chk("pass_run.count", 32'(store_count), 32'(vecs[i].cnt));
            chk("pass_run.pass",  32'(pass),        32'(vecs[i].pass));
        end
        chk("pass_run.done",    32'(done),    32'd1);
        chk("pass_run.fail",    32'(fail),    32'd0);
        chk("pass_run.timeout", 32'(timeout), 32'd0);
        drain("pass_log");

        // pop while empty holds last head
        log_pop = 1'b1;
        step();
        log_pop = 1'b0;
        chk("empty_pop.valid", 32'(log_valid), 32'd0);
        chk("empty_pop.addr",  log_addr, 32'd84);
        chk("empty_pop.data",  log_data, 32'd7);

        // store in terminal state ignored
        drive_store(32'd80, 32'd1, 1'b0);
        chk("terminal.count", 32'(store_count), 32'd3);
        chk("terminal.valid", 32'(log_valid),   32'd0);
        chk("terminal.pass",  32'(pass),        32'd1);

        // clear with a pass store in the same cycle
        clear = 1'b1;
        memwrite = 1'b1;
        dataadr = 32'd84;
        writedata = 32'd7;
        step();
        clear = 1'b0;
        memwrite = 1'b0;
        chk("clear.pass",  32'(pass),        32'd0);
        chk("clear.done",  32'(done),        32'd0);
        chk("clear.count", 32'(store_count), 32'd0);
        chk("clear.valid", 32'(log_valid),   32'd0);
        step();
        chk("clear.late_pass", 32'(pass), 32'd0);

        // overflow: nine stores into an eight-entry log
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_store(32'd80, 32'(i), (i < 8));
        end
        chk("ovf.flag",  32'(log_overflow), 32'd1);
        chk("ovf.count", 32'(store_count),  32'd9);
        drain("ovf_log");
        chk("ovf.sticky", 32'(log_overflow), 32'd1);

        // full log with simultaneous push and pop
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovf_clear.flag", 32'(log_overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive_store(32'd80, 32'(100 + i), 1'b1);
        end
        chk("fullpop.head", log_data, 32'd100);
        memwrite = 1'b1;
        dataadr = 32'd80;
        writedata = 32'd108;
        log_pop = 1'b1;
        step();
        memwrite = 1'b0;
        log_pop = 1'b0;
        void'(sb.pop_front());
        sb.push_back('{a: 32'd80, d: 32'd108});
        chk("fullpop.flag",  32'(log_overflow), 32'd0);
        chk("fullpop.count", 32'(store_count),  32'd9);
        drain("fullpop_log");

        // verdict on illegal store (strict) or timeout (default)
        clear = 1'b1;
        step();
        clear = 1'b0;
`ifdef STORE_MONITOR_STRICT_EN
        drive_store(32'd84, 32'd3, 1'b1);
        chk("strict.fail",    32'(fail),        32'd1);
        chk("strict.done",    32'(done),        32'd1);
        chk("strict.pass",    32'(pass),        32'd0);
        chk("strict.timeout", 32'(timeout),     32'd0);
        chk("strict.count",   32'(store_count), 32'd1);
        drive_store(32'd84, 32'd7, 1'b0);
        chk("strict.ignored_count", 32'(store_count), 32'd1);
        chk("strict.ignored_pass",  32'(pass),        32'd0);
        chk("strict.still_fail",    32'(fail),        32'd1);
        drain("strict_log");
`else
        drive_store(32'd96, 32'd1, 1'b1);
        drive_store(32'd84, 32'd3, 1'b1);
        chk("tmo.no_fail_early", 32'(done), 32'd0);
        for (int k = 3; k <= 20; k++) begin
            step();
            if (k == 19) begin
                chk("tmo.before", 32'(timeout), 32'd0);
                chk("tmo.before_done", 32'(done), 32'd0);
            end
        end
        chk("tmo.timeout", 32'(timeout),     32'd1);
        chk("tmo.fail",    32'(fail),        32'd1);
        chk("tmo.done",    32'(done),        32'd1);
        chk("tmo.pass",    32'(pass),        32'd0);
        chk("tmo.count",   32'(store_count), 32'd2);
        drain("tmo_log");
`endif

        // reset mid-run overrides clear and a pass store
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive_store(32'd80, 32'd1, 1'b0);
        drive_store(32'd80, 32'd2, 1'b0);
        drive_store(32'd80, 32'd3, 1'b0);
        chk("midrun.count", 32'(store_count), 32'd3);
        chk("midrun.valid", 32'(log_valid),   32'd1);
        reset = 1'b0;
        clear = 1'b1;
        memwrite = 1'b1;
        dataadr = 32'd84;
        writedata = 32'd7;
        step();
        memwrite = 1'b0;
        clear = 1'b0;
        chk_zero("midrun_reset");
        reset = 1'b1;
        step();
        chk("resume.done", 32'(done), 32'd0);
        drive_store(32'd80, 32'd9, 1'b1);
        chk("resume.count", 32'(store_count), 32'd1);
        drain("resume_log");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_ADDR, 32'd84, store address that signals test completion.
REQ-002 Parameter PASS_DATA, 32'd7, data value that must accompany a store to PASS_ADDR for success.
REQ-003 Parameter SCRATCH_ADDR, 32'd80, store address permitted during a run without ending it.
REQ-004 Parameter TIMEOUT_CYCLES, 1000, run cycles allowed before timeout.
REQ-005 Parameter LOG_DEPTH, 8, store-log entries (power of two, >=2).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-008 memwrite  in  1  processor store strobe, one store per cycle high.
REQ-009 dataadr  in  32  store byte address.
REQ-010 writedata  in  32  store data.
REQ-011 clear  in  1  restart monitoring; returns block to RUN.
REQ-012 done / pass / fail / timeout  out  1 each  registered verdict flags.
REQ-013 store_count  out  16  stores accepted in current run.
REQ-014 log_pop  in  1  consume head of store log.
REQ-015 log_valid  out  1  log non-empty; log_addr/log_data (32 each) show head entry.
REQ-016 log_overflow  out  1  sticky; a store was dropped because the log was full.

Function
REQ-017 States SHALL be RUN, PASS, FAIL, TIMEOUT; PASS/FAIL/TIMEOUT are terminal and sticky until clear or reset.
REQ-018 In RUN, memwrite=1 with dataadr==PASS_ADDR and writedata==PASS_DATA SHALL move to PASS; pass and done high the next cycle.
REQ-019 In RUN, a cycle counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES-1 without a verdict, move to TIMEOUT; timeout, fail, done high the next cycle.
REQ-020 A verdict-causing store and the timeout on the same cycle SHALL resolve to the store's verdict.
REQ-021 Every store in RUN, including the verdict store, SHALL increment store_count (saturating at 16'hFFFF) and push {dataadr, writedata} to the log.
REQ-022 Stores in terminal states SHALL be ignored: no count, no log push.
REQ-023 Log full and push without pop SHALL drop the entry and set log_overflow; full with simultaneous push and pop SHALL accept both.
REQ-024 log_pop while empty SHALL be ignored; log_addr/log_data hold last values.
REQ-025 clear SHALL return to RUN, zero counters, empty log, clear all flags including log_overflow; a store in the clear cycle is ignored.
REQ-026 Verdict flags are mutually exclusive except fail, which accompanies timeout; done = pass|fail.

Reset
REQ-027 reset=0 at a rising edge SHALL force RUN, done/pass/fail/timeout=0, store_count=0, cycle counter=0, log empty, log_valid=0, log_overflow=0, log_addr/log_data=0, regardless of state or mid-run activity.
REQ-028 reset SHALL take priority over clear and memwrite.

Configuration
REQ-029 Macro STORE_MONITOR_STRICT_EN: when defined, in RUN a store to PASS_ADDR with data!=PASS_DATA, or to any address other than PASS_ADDR/SCRATCH_ADDR, SHALL move to FAIL (fail, done next cycle).
REQ-030 Without STORE_MONITOR_STRICT_EN, such stores SHALL only be counted and logged; the run ends only by PASS or TIMEOUT.

Structure
REQ-031 Package store_monitor_pkg SHALL hold the state enum and the log-entry struct {addr[31:0], data[31:0]}.
REQ-032 Log SHALL be a sub-module store_log_fifo (parameter LOG_DEPTH, push/pop/full/empty/overflow).

Verification
REQ-033 Reset low 2 cycles, then stores (80,5),(80,6),(84,7) -> pass=1, done=1 one cycle after third store; store_count=3; log pops 80/5, 80/6, 84/7.
REQ-034 STRICT_EN defined: store (84,3) -> fail=1, done=1 next cycle; subsequent (84,7) ignored, store_count stays 1.
REQ-035 STRICT_EN undefined: stores (96,1),(84,3), no further stores, TIMEOUT_CYCLES=20 -> timeout=fail=done=1 at cycle 20, store_count=2.
REQ-036 LOG_DEPTH=8, 9 stores to 80 without pop -> log_overflow=1, 8 entries popped, store_count=9; repeat with pop on 9th-store cycle -> no overflow.
REQ-037 clear together with store (84,7) in RUN -> no pass, store_count=0, log empty.
REQ-038 reset=0 asserted mid-run with 3 logged entries -> all outputs zero next cycle, RUN resumes after reset=1.
